// File: rtl/plab2_proc_int_muldiv_iter_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package plab2_proc_int_muldiv_iter_pkg;

    localparam int MD_NBITS = 32;
    localparam int MD_CNT_W = $clog2(MD_NBITS);

    typedef enum logic [2:0] {
        MD_MUL  = 3'd0,
        MD_DIV  = 3'd1,
        MD_DIVU = 3'd2,
        MD_REM  = 3'd3,
        MD_REMU = 3'd4
    } md_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Codes 5..7 fall through every predicate below and so behave as MUL.
    function automatic logic fn_is_div(input logic [2:0] fn);
        return (fn == MD_DIV) || (fn == MD_DIVU) || (fn == MD_REM) || (fn == MD_REMU);
    endfunction

    function automatic logic fn_is_signed(input logic [2:0] fn);
        return (fn == MD_DIV) || (fn == MD_REM);
    endfunction

    function automatic logic fn_is_rem(input logic [2:0] fn);
        return (fn == MD_REM) || (fn == MD_REMU);
    endfunction

endpackage

// File: rtl/plab2_proc_int_muldiv_iter_if.sv
// Request/response val/rdy bundle between the X stage and the muldiv unit.
interface plab2_proc_int_muldiv_iter_if #(
    parameter int p_nbits = 32
);
    logic               req_val;
    logic               req_rdy;
    logic [2:0]         req_fn;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;
    logic               resp_val;
    logic               resp_rdy;
    logic [p_nbits-1:0] resp_data;

    modport master (
        output req_val, req_fn, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_fn, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_data
    );
endinterface

// File: rtl/plab2_proc_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; fed back through
// the operand/accumulator registers in the top.
module plab2_proc_muldiv_step #(
    parameter int p_nbits = 32
) (
    input  logic               is_mul,
    input  logic [p_nbits-1:0] a,
    input  logic [p_nbits-1:0] b,
    input  logic [p_nbits-1:0] acc,
    output logic [p_nbits-1:0] a_nxt,
    output logic [p_nbits-1:0] b_nxt,
    output logic [p_nbits-1:0] acc_nxt
);

    // One extra bit so the shifted partial remainder never overflows.
    logic [p_nbits:0] shifted;
    logic [p_nbits:0] diff;
    logic             ge;

    always_comb begin
        shifted = {acc, a[p_nbits-1]};
        diff    = shifted - {1'b0, b};
        ge      = (shifted >= {1'b0, b});
        a_nxt   = a;
        b_nxt   = b;
        acc_nxt = acc;
        if (is_mul) begin
            acc_nxt = b[0] ? (acc + a) : acc;
            a_nxt   = a << 1;
            b_nxt   = b >> 1;
        end else begin
            acc_nxt = ge ? diff[p_nbits-1:0] : shifted[p_nbits-1:0];
            a_nxt   = {a[p_nbits-2:0], ge};
        end
    end

endmodule

// File: rtl/plab2_proc_int_muldiv_iter.sv
// Iterative multiply/divide unit: p_nbits steps per op, val/rdy on both sides.
module plab2_proc_int_muldiv_iter
    import plab2_proc_int_muldiv_iter_pkg::*;
#(
    parameter int p_nbits = MD_NBITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sd,
    plab2_proc_int_muldiv_iter_if.slave     io
);

    localparam int                 c_cnt_w = $clog2(p_nbits);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(p_nbits - 1);

    md_state_e          state;
    logic [c_cnt_w-1:0] cnt;
    logic [2:0]         fn_reg;
    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] acc;
    logic               neg_res;
    logic               b_zero;
    logic               rdy_reg;
    logic               val_reg;
    logic [p_nbits-1:0] data_reg;

    logic [p_nbits-1:0] a_nxt;
    logic [p_nbits-1:0] b_nxt;
    logic [p_nbits-1:0] acc_nxt;
    logic [p_nbits-1:0] result;
    logic               in_signed;

    // The domain label only tags the datapath; it has no functional effect.
    logic unused_sd;
    assign unused_sd = sd;

    assign io.req_rdy   = rdy_reg;
    assign io.resp_val  = val_reg;
    assign io.resp_data = data_reg;
    assign in_signed    = fn_is_signed(io.req_fn);

    plab2_proc_muldiv_step #(.p_nbits(p_nbits)) u_step (
        .is_mul  (!fn_is_div(fn_reg)),
        .a       (a_reg),
        .b       (b_reg),
        .acc     (acc),
        .a_nxt   (a_nxt),
        .b_nxt   (b_nxt),
        .acc_nxt (acc_nxt)
    );

    // Divide-by-zero quotient stays all-ones whatever the operand signs.
    always_comb begin
        result = acc_nxt;
        if (fn_is_rem(fn_reg)) begin
            result = neg_res ? -acc_nxt : acc_nxt;
        end else if (fn_is_div(fn_reg)) begin
            result = (neg_res && !b_zero) ? -a_nxt : a_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            fn_reg   <= MD_MUL;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            b_zero   <= 1'b0;
            rdy_reg  <= 1'b1;
            val_reg  <= 1'b0;
            data_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.req_val && rdy_reg) begin
                        fn_reg  <= io.req_fn;
                        a_reg   <= (in_signed && io.req_a[p_nbits-1]) ? -io.req_a : io.req_a;
                        b_reg   <= (in_signed && io.req_b[p_nbits-1]) ? -io.req_b : io.req_b;
                        acc     <= '0;
                        cnt     <= '0;
                        neg_res <= in_signed && (fn_is_rem(io.req_fn)
                                   ? io.req_a[p_nbits-1]
                                   : (io.req_a[p_nbits-1] ^ io.req_b[p_nbits-1]));
                        b_zero  <= (io.req_b == '0);
                        rdy_reg <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_reg <= a_nxt;
                    b_reg <= b_nxt;
                    acc   <= acc_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == c_last) begin
                        data_reg <= result;
                        val_reg  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io.resp_rdy) begin
                        val_reg <= 1'b0;
                        rdy_reg <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    val_reg <= 1'b0;
                    rdy_reg <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
